// File: rtl/seq_add_pkg.sv
// Shared types for the sequential chunked adder: FSM state encoding and its width.
package seq_add_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  // NOTE: blocking assignments in always_comb so each bit sees the carry computed just above it.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: o = a + b + cin, CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed-overflow output enabled by defining SEQ_ADD_OVF_EN.
module seq_chunk_adder
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
`ifdef SEQ_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("seq_chunk_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   o_q, o_d;
`ifdef SEQ_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0]   a_chunk, b_chunk, s_chunk;
  logic               c_chunk;
  logic               last_chunk;

  // A single adder slice is time-multiplexed across all chunks.
  assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a (a_chunk),
    .b (b_chunk),
    .ci(carry_q),
    .s (s_chunk),
    .co(c_chunk)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    o_d     = o_q;
`ifdef SEQ_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        o_d[idx_q*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          state_d = DONE;
`ifdef SEQ_ADD_OVF_EN
          // The final chunk's top sum bit is the result MSB.
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef SEQ_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      o_q     <= '0;
`ifdef SEQ_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      o_q     <= o_d;
`ifdef SEQ_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // NOTE: operand latches carry no reset; they are always reloaded on accept before being read.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign o         = o_q;
  assign cout      = carry_q;
`ifdef SEQ_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: 8/2 instance (directed + random) and 4/1 instance (sweep).
module tb_seq_chunk_adder;

  localparam int W  = 8, C  = 2, N  = W / C;
  localparam int W2 = 4, C2 = 1, N2 = W2 / C2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, busy, ovf;
  logic [W-1:0]  a, b, o;
  logic          in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2, ovf2;
  logic [W2-1:0] a2, b2, o2;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .cout(cout),
`ifdef SEQ_ADD_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  seq_chunk_adder #(.WIDTH(W2), .CHUNK(C2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .o(o2), .cout(cout2),
`ifdef SEQ_ADD_OVF_EN
    .ovf(ovf2),
`endif
    .busy(busy2)
  );

`ifndef SEQ_ADD_OVF_EN
  assign ovf  = 1'b0;
  assign ovf2 = 1'b0;
`endif

  typedef struct {
    logic [W:0] sum;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic; overflow = signed result out of range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    int   s;
    e.sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s     = int'($signed(x)) + int'($signed(y)) + int'(ci);
    e.ovf = (s > 127) || (s < -128);
    e.acc = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    int   k = 0;
    in_valid = 1'b1; a = x; b = y; cin = ci;
    while (!in_ready && k < 200) begin step(); k++; end
    if (k == 200) check("send1_in_ready_timeout", 0, 1);
    step();
    e = model(x, y, ci);
    e.acc = cyc;
    q1.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic ci);
    exp_t e;
    int   k = 0;
    in_valid2 = 1'b1; a2 = x; b2 = y; cin2 = ci;
    while (!in_ready2 && k < 200) begin step(); k++; end
    if (k == 200) check("send2_in_ready_timeout", 0, 1);
    step();
    e.sum = (W + 1)'(int'(x) + int'(y) + int'(ci));
    e.ovf = 1'b0;
    e.acc = cyc;
    q2.push_back(e);
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q1.size() != 0 || q2.size() != 0) && k < 500) begin step(); k++; end
    if (k == 500) check("drain_timeout", 0, 1);
  endtask

  // Monitor for the 8/2 instance.
  initial begin
    logic         pv = 1'b0, pr = 1'b0, pc = 1'b0;
    logic [W-1:0] po = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        check("m1_in_ready_vs_busy", in_ready, !busy);
        if (out_valid && !pv) begin
          if (q1.size() == 0) check("m1_spurious_out_valid", 0, 1);
          else check("m1_latency", cyc - q1[0].acc, N);
        end
        if (out_valid && pv && !pr) begin
          check("m1_hold_o", o, po);
          check("m1_hold_cout", cout, pc);
        end
        if (out_valid && out_ready && q1.size() != 0) begin
          e = q1.pop_front();
          check("m1_o", o, e.sum[W-1:0]);
          check("m1_cout", cout, e.sum[W]);
`ifdef SEQ_ADD_OVF_EN
          check("m1_ovf", ovf, e.ovf);
`endif
        end
        pv = out_valid; pr = out_ready; po = o; pc = cout;
      end
    end
  end

  // Monitor for the 4/1 instance.
  initial begin
    logic pv = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (out_valid2 && !pv) begin
          if (q2.size() == 0) check("m2_spurious_out_valid", 0, 1);
          else check("m2_latency", cyc - q2[0].acc, N2);
        end
        if (out_valid2 && out_ready2 && q2.size() != 0) begin
          e = q2.pop_front();
          check("m2_o", o2, e.sum[W2-1:0]);
          check("m2_cout", cout2, e.sum[W2]);
`ifdef SEQ_ADD_OVF_EN
          check("m2_ovf", ovf2, 1'b0);
`endif
        end
        pv = out_valid2;
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_o", o, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst2_in_ready", in_ready2, 1);
    check("rst2_o", o2, 0);

    // Basic add; block must refuse operands while working.
    send1(8'h0F, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t1_in_ready_low", in_ready, 0);
      step();
    end
    drain();

    // Carry propagation through every chunk, plus boundary and overflow vectors.
    send1(8'hFF, 8'h01, 1'b0);
    send1(8'hFF, 8'hFF, 1'b1);
    send1(8'h7F, 8'h01, 1'b0);
    send1(8'h80, 8'h80, 1'b0);
    send1(8'h10, 8'h20, 1'b0);
    send1(8'h00, 8'h00, 1'b1);
    drain();

    // Backpressure in DONE for 5 cycles.
    out_ready = 1'b0;
    send1(8'hA5, 8'h5B, 1'b1);
    k = 0;
    while (!out_valid && k < 50) begin step(); k++; end
    if (k == 50) check("t3_out_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_out_valid_held", out_valid, 1);
      check("t3_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("t3_idle_in_ready", in_ready, 1);
    check("t3_idle_out_valid", out_valid, 0);

    // Reset two cycles into RUN discards the operation.
    send1(8'hC3, 8'h3C, 1'b1);
    step();
    rst = 1'b1;
    void'(q1.pop_back());
    step();
    rst = 1'b0;
    check("t4_in_ready", in_ready, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_o", o, 0);
    check("t4_cout", cout, 0);
    check("t4_busy", busy, 0);
    check("t4_ovf", ovf, 0);
    repeat (6) begin
      step();
      check("t4_no_out_valid", out_valid, 0);
    end
    send1(8'h33, 8'h44, 1'b0);
    drain();

    // Narrow instance: sweep b with back-to-back handshakes.
    for (int i = 0; i < 16; i++) send2(4'h0, 4'(i), 1'b0);
    drain();

    // Random operands and carry-in.
    for (int i = 0; i < 60; i++) send1(8'($urandom), 8'($urandom), 1'($urandom));
    drain();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
